dds_top: RTL and testbench
==========================

# dds_top

Direct digital synthesizer: 16-bit phase accumulator, quarter-wave sine lookup, 4-bit amplitude scaling, and a 13-bit offset-binary sample stream for a DAC. It sits behind a simple write-only register bus driven by the host/control logic. The bus sets frequency, amplitude and run/stop. Single clock domain; no read-back path.

## Interface
- No parameters; all widths fixed.
- clk  in  1  system clock, rising edge
- rstn  in  1  asynchronous, active-low reset
- wr  in  1  write strobe, one cycle per write
- waddr  in  16  register address
- wdata  in  16  write data
- out_valid  out  1  dout carries a valid sample
- dout  out  13  sample, offset binary, midscale 4096

## Operation
- Register map (unmapped addresses ignored, no side effects):
  - 0x10 CTRL: bit0 EN (reset 1), bit1 CLR (self-clearing; zeroes the accumulator on the write edge), other bits ignored.
  - 0x20 FTW: 16-bit phase increment (reset 0x0000).
  - 0x30 AMP: wdata[3:0] (reset 0xF).
- Accumulator: acc <= acc + FTW, mod 2^16, every edge while EN=1; holds while EN=0. CLR has priority over increment.
- Phase decode uses acc[15:8]:
  - q = acc[15:14], idx = acc[13:8].
  - Index mirror: q[0]=1 uses ~idx.
  - Sign: q[1]=1 negates.
- LUT: 64 entries × 12-bit magnitude. mag[i] = round(4095·sin(π/2·(i+0.5)/64)). mag[0]=50, mag[63]=4095.
- s = ±mag, signed 13-bit, range −4095..4095.
- Scaling: scaled = (s·(AMP+1)) >>> 4, arithmetic shift, truncates toward −∞.
- Output: dout = 4096 + scaled. Range 1..8191; never overflows.

## Timing
- Reset state: acc=0, all pipeline registers 0, dout=0, out_valid=0, registers at reset values.
- Register write takes effect on the wr edge. A new FTW first affects the increment on the following edge.
- Three-stage pipeline:
  - P1 registers q/idx from acc.
  - P2 registers s.
  - P3 registers dout.
- dout at edge n reflects acc as held before edge n−2, giving 3 edges of latency.
- After rstn release with EN=1, out_valid rises on the 3rd rising edge. The first dout is the phase-0 sample.
- A per-stage valid bit, set by EN, travels with the data.
  - EN=0: out_valid drops 3 edges later. dout holds its last value.
  - EN re-asserted: out_valid returns 3 edges later.
- AMP change: visible at dout 1 edge after it is registered (applied in P3).
- Reset asserted mid-operation: everything returns to reset state immediately and asynchronously.
- GSR is a vendor global set/reset primitive instantiated by the bench and tied inactive. The block must not depend on it.

## Structure
- Shared package dds_pkg holds:
  - Address constants ADDR_CTRL=16'h10, ADDR_FTW=16'h20, ADDR_AMP=16'h30.
  - Widths: PHASE_W=16, OUT_W=13, LUT_AW=6, MAG_W=12.
  - Reset values, including AMP_RST=4'hF.
- Sub-module dds_sin_lut: combinational 6-bit address → 12-bit magnitude case table, registered in P2 by dds_top.
- dds_top contains the register file, accumulator, quadrant logic, scaling and pipeline.

## Test plan
- Reset then idle (FTW=0, AMP=F):
  - During reset: dout=0, out_valid=0.
  - out_valid=1 at 3rd edge after release.
  - dout constant 0x1032 (4146).
- Write AMP=0x7 at 0x30: 1 edge after the write lands, dout=4121. Write AMP=0x0: dout=4099.
- Write FTW=0x4000 (AMP=F): dout cycles 4146, 8191, 4046, 1 repeating, first new value 4 edges after the write edge.
- Write FTW=0x0002 then run 200 cycles: dout monotonically non-decreasing from 4146. acc[15:8] increments by 1 every 128 cycles.
- Write CTRL=0x0000: acc frozen, out_valid falls 3 edges later, dout held. Write CTRL=0x0003: acc zeroed, out_valid returns after 3 edges with dout=4146 (FTW=0).
- Write to 0x50 and 0x21: no register change, output stream unaffected. Assert rstn low mid-stream: dout=0, out_valid=0 immediately.

Source files
------------

// File: rtl/dds_pkg.sv
// Shared constants and pipeline bundles for the DDS sample generator.
// Register map, widths and reset values live here.
package dds_pkg;

  localparam int PHASE_W = 16;
  localparam int OUT_W   = 13;
  localparam int LUT_AW  = 6;
  localparam int MAG_W   = 12;

  localparam logic [15:0] ADDR_CTRL = 16'h10;
  localparam logic [15:0] ADDR_FTW  = 16'h20;
  localparam logic [15:0] ADDR_AMP  = 16'h30;

  localparam logic               EN_RST  = 1'b1;
  localparam logic [PHASE_W-1:0] FTW_RST = '0;
  localparam logic [3:0]         AMP_RST = 4'hF;

  localparam logic [OUT_W-1:0] MID = 13'd4096;

  typedef struct packed {
    logic              vld;
    logic [1:0]        q;
    logic [LUT_AW-1:0] idx;
  } p1_t;

  typedef struct packed {
    logic             vld;
    logic [OUT_W-1:0] s;
  } p2_t;

endpackage

// File: rtl/dds_sin_lut.sv
// Quarter-wave sine magnitude table, half-LSB phase offset.
// mag[i] = round(4095 * sin(pi/2 * (i + 0.5) / 64)).
module dds_sin_lut
  import dds_pkg::*;
(
  input  logic [LUT_AW-1:0] addr,
  output logic [MAG_W-1:0]  mag
);

  always_comb begin
    mag = '0;
    unique case (addr)
      6'd0:  mag = 12'd50;
      6'd1:  mag = 12'd151;
      6'd2:  mag = 12'd251;
      6'd3:  mag = 12'd351;
      6'd4:  mag = 12'd451;
      6'd5:  mag = 12'd551;
      6'd6:  mag = 12'd651;
      6'd7:  mag = 12'd750;
      6'd8:  mag = 12'd848;
      6'd9:  mag = 12'd946;
      6'd10: mag = 12'd1044;
      6'd11: mag = 12'd1141;
      6'd12: mag = 12'd1237;
      6'd13: mag = 12'd1332;
      6'd14: mag = 12'd1427;
      6'd15: mag = 12'd1521;
      6'd16: mag = 12'd1613;
      6'd17: mag = 12'd1705;
      6'd18: mag = 12'd1796;
      6'd19: mag = 12'd1886;
      6'd20: mag = 12'd1975;
      6'd21: mag = 12'd2062;
      6'd22: mag = 12'd2148;
      6'd23: mag = 12'd2233;
      6'd24: mag = 12'd2317;
      6'd25: mag = 12'd2399;
      6'd26: mag = 12'd2480;
      6'd27: mag = 12'd2559;
      6'd28: mag = 12'd2636;
      6'd29: mag = 12'd2713;
      6'd30: mag = 12'd2787;
      6'd31: mag = 12'd2860;
      6'd32: mag = 12'd2931;
      6'd33: mag = 12'd3000;
      6'd34: mag = 12'd3068;
      6'd35: mag = 12'd3133;
      6'd36: mag = 12'd3197;
      6'd37: mag = 12'd3259;
      6'd38: mag = 12'd3319;
      6'd39: mag = 12'd3377;
      6'd40: mag = 12'd3433;
      6'd41: mag = 12'd3486;
      6'd42: mag = 12'd3538;
      6'd43: mag = 12'd3588;
      6'd44: mag = 12'd3635;
      6'd45: mag = 12'd3680;
      6'd46: mag = 12'd3723;
      6'd47: mag = 12'd3764;
      6'd48: mag = 12'd3802;
      6'd49: mag = 12'd3838;
      6'd50: mag = 12'd3872;
      6'd51: mag = 12'd3904;
      6'd52: mag = 12'd3933;
      6'd53: mag = 12'd3960;
      6'd54: mag = 12'd3984;
      6'd55: mag = 12'd4006;
      6'd56: mag = 12'd4026;
      6'd57: mag = 12'd4043;
      6'd58: mag = 12'd4058;
      6'd59: mag = 12'd4070;
      6'd60: mag = 12'd4080;
      6'd61: mag = 12'd4087;
      6'd62: mag = 12'd4092;
      6'd63: mag = 12'd4095;
    endcase
  end

endmodule

// File: rtl/dds_top.sv
// DDS: register file, phase accumulator and 3-stage
// sine/scale pipeline producing an offset-binary DAC stream.
module dds_top
  import dds_pkg::*;
(
  input  logic             clk,
  input  logic             rstn,
  input  logic             wr,
  input  logic [15:0]      waddr,
  input  logic [15:0]      wdata,
  output logic             out_valid,
  output logic [OUT_W-1:0] dout
);

  logic               wr_ctrl, wr_ftw, wr_amp;
  logic               en_q, en_d;
  logic [PHASE_W-1:0] ftw_q, ftw_d;
  logic [3:0]         amp_q, amp_d;
  logic [PHASE_W-1:0] acc_q, acc_d;
  p1_t                p1_q, p1_d;
  p2_t                p2_q, p2_d;
  logic               vld3_q, vld3_d;
  logic [OUT_W-1:0]   dout_q, dout_d;

  logic [LUT_AW-1:0]       lut_a;
  logic [MAG_W-1:0]        lut_mag;
  logic signed [OUT_W-1:0] mag_s;
  logic [4:0]              amp_p1;
  logic signed [18:0]      prod;
  logic [OUT_W-1:0]        scaled_u;
  logic                    unused_bits;

  assign wr_ctrl = wr && (waddr == ADDR_CTRL);
  assign wr_ftw  = wr && (waddr == ADDR_FTW);
  assign wr_amp  = wr && (waddr == ADDR_AMP);

  always_comb begin
    en_d  = en_q;
    ftw_d = ftw_q;
    amp_d = amp_q;
    unique case (1'b1)
      wr_ctrl: en_d  = wdata[0];
      wr_ftw:  ftw_d = wdata;
      wr_amp:  amp_d = wdata[3:0];
      default: ;
    endcase
    acc_d = acc_q;
    if (wr_ctrl && wdata[1])
      acc_d = '0;
    else if (en_q)
      acc_d = acc_q + ftw_q;
  end

  dds_sin_lut u_lut (
    .addr (lut_a),
    .mag  (lut_mag)
  );

  // Odd quadrants read the table backwards; q[1] selects the negative half.
  assign lut_a = p1_q.q[0] ? ~p1_q.idx : p1_q.idx;
  assign mag_s = $signed({1'b0, lut_mag});

  // Product floor-shifted by 4 always fits 13 bits: |s*16|/16 <= 4095.
  assign amp_p1      = {1'b0, amp_q} + 5'd1;
  assign prod        = 19'($signed(p2_q.s)) * 19'($signed({1'b0, amp_p1}));
  assign scaled_u    = prod[16:4];
  assign unused_bits = ^{prod[18:17], prod[3:0]};

  always_comb begin
    p1_d     = p1_q;
    p1_d.vld = en_q;
    if (en_q) begin
      p1_d.q   = acc_q[15:14];
      p1_d.idx = acc_q[13:8];
    end
    p2_d     = p2_q;
    p2_d.vld = p1_q.vld;
    if (p1_q.vld)
      p2_d.s = p1_q.q[1] ? -mag_s : mag_s;
    vld3_d = p2_q.vld;
    dout_d = dout_q;
    if (p2_q.vld)
      dout_d = MID + scaled_u;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      en_q   <= EN_RST;
      ftw_q  <= FTW_RST;
      amp_q  <= AMP_RST;
      acc_q  <= '0;
      p1_q   <= '0;
      p2_q   <= '0;
      vld3_q <= 1'b0;
      dout_q <= '0;
    end else begin
      en_q   <= en_d;
      ftw_q  <= ftw_d;
      amp_q  <= amp_d;
      acc_q  <= acc_d;
      p1_q   <= p1_d;
      p2_q   <= p2_d;
      vld3_q <= vld3_d;
      dout_q <= dout_d;
    end
  end

  assign out_valid = vld3_q;
  assign dout      = dout_q;

endmodule

// File: tb/tb_dds_top.sv
// Bench for dds_top: directed vector table, then random register
// traffic checked against a real-valued sine reference model.
module tb_dds_top;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        wr = 1'b0;
  logic [15:0] waddr = '0;
  logic [15:0] wdata = '0;
  logic        out_valid;
  logic [12:0] dout;

  int n_pass = 0;
  int n_chk  = 0;

  dds_top dut (
    .clk       (clk),
    .rstn      (rstn),
    .wr        (wr),
    .waddr     (waddr),
    .wdata     (wdata),
    .out_valid (out_valid),
    .dout      (dout)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d", name, act, exp);
  endtask

  // Reference model: behaviour from the rules, not the pipeline.
  typedef struct {
    bit en;
    int acc;
  } hs_t;

  hs_t hist[$];
  int  m_acc, m_ftw, m_amp, m_dout;
  bit  m_en, m_vld;

  function automatic int sine_s(input int acc);
    int  p, mag;
    real a, v;
    p   = (acc >> 8) & 255;
    a   = 2.0 * 3.141592653589793 * (real'(p) + 0.5) / 256.0;
    v   = 4095.0 * $sin(a);
    mag = $rtoi($floor((v < 0.0 ? -v : v) + 0.5));
    return (v < 0.0) ? -mag : mag;
  endfunction

  function automatic int exp_dout(input int s, input int amp);
    return 4096 + $rtoi($floor(real'(s * (amp + 1)) / 16.0));
  endfunction

  task automatic model_reset();
    hs_t z;
    z.en = 1'b0;
    z.acc = 0;
    m_acc = 0; m_ftw = 0; m_amp = 15;
    m_en = 1'b1; m_dout = 0; m_vld = 1'b0;
    hist.delete();
    for (int i = 0; i < 3; i++) hist.push_back(z);
  endtask

  task automatic model_edge(input bit w, input int a, input int d);
    hs_t e;
    e.en = m_en;
    e.acc = m_acc;
    hist.push_back(e);
    void'(hist.pop_front());
    m_vld = hist[0].en;
    if (m_vld) m_dout = exp_dout(sine_s(hist[0].acc), m_amp);
    if (w && a == 'h10 && d[1]) m_acc = 0;
    else if (m_en) m_acc = (m_acc + m_ftw) & 'hFFFF;
    if (w) begin
      if (a == 'h10) m_en = d[0];
      else if (a == 'h20) m_ftw = d & 'hFFFF;
      else if (a == 'h30) m_amp = d & 'hF;
    end
  endtask

  task automatic tick(input bit w, input logic [15:0] a,
                      input logic [15:0] d);
    wr = w; waddr = a; wdata = d;
    @(posedge clk);
    model_edge(w, int'(a), int'(d));
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic check_model(input string tag);
    check({tag, " valid"}, int'(out_valid), int'(m_vld));
    check({tag, " dout"}, int'(dout), m_dout);
  endtask

  typedef struct {
    bit          w;
    logic [15:0] a;
    logic [15:0] d;
    bit          v;
    int          o;
  } vec_t;

  vec_t tv[$];

  task automatic add(input bit w, input logic [15:0] a,
                     input logic [15:0] d, input bit v, input int o);
    vec_t t;
    t.w = w; t.a = a; t.d = d; t.v = v; t.o = o;
    tv.push_back(t);
  endtask

  int prev, viol;

  initial begin
    add(0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 4146);
    add(0, 0, 0, 1, 4146);
    add(1, 'h30, 'h7, 1, 4146);
    add(0, 0, 0, 1, 4121);
    add(1, 'h30, 'h0, 1, 4121);
    add(0, 0, 0, 1, 4099);
    add(1, 'h30, 'hF, 1, 4099);
    add(0, 0, 0, 1, 4146);
    add(1, 'h20, 'h4000, 1, 4146);
    add(0, 0, 0, 1, 4146);
    add(0, 0, 0, 1, 4146);
    add(0, 0, 0, 1, 4146);
    add(0, 0, 0, 1, 8191);
    add(0, 0, 0, 1, 4046);
    add(0, 0, 0, 1, 1);
    add(0, 0, 0, 1, 4146);
    add(0, 0, 0, 1, 8191);
    add(1, 'h10, 'h0, 1, 4046);
    add(0, 0, 0, 1, 1);
    add(0, 0, 0, 1, 4146);
    add(0, 0, 0, 0, 4146);
    add(0, 0, 0, 0, 4146);
    add(1, 'h20, 'h0, 0, 4146);
    add(1, 'h10, 'h3, 0, 4146);
    add(0, 0, 0, 0, 4146);
    add(0, 0, 0, 0, 4146);
    add(0, 0, 0, 1, 4146);
    add(1, 'h50, 'h0, 1, 4146);
    add(1, 'h21, 'h1234, 1, 4146);
    for (int i = 0; i < 5; i++) add(0, 0, 0, 1, 4146);

    model_reset();
    #12;
    check("reset valid", int'(out_valid), 0);
    check("reset dout", int'(dout), 0);
    @(negedge clk);
    rstn = 1'b1;

    foreach (tv[i]) begin
      tick(tv[i].w, tv[i].a, tv[i].d);
      check($sformatf("vec%0d valid", i), int'(out_valid), int'(tv[i].v));
      check($sformatf("vec%0d dout", i), int'(dout), tv[i].o);
    end

    tick(1, 'h20, 'h0002);
    prev = int'(dout);
    viol = 0;
    for (int i = 0; i < 200; i++) begin
      tick(0, 0, 0);
      check_model($sformatf("ramp%0d", i));
      if (int'(dout) < prev) viol++;
      prev = int'(dout);
    end
    check("ramp monotonic violations", viol, 0);
    check("ramp end dout", int'(dout), 4247);

    for (int i = 0; i < 400; i++) begin
      logic [15:0] d, ua;
      int r;
      r = int'($urandom_range(0, 9));
      d = 16'($urandom);
      case (int'($urandom_range(0, 5)))
        0: ua = 16'h50;
        1: ua = 16'h21;
        2: ua = 16'h11;
        3: ua = 16'h00;
        4: ua = 16'hFFFF;
        default: ua = 16'h1030;
      endcase
      if (r == 0) begin
        d[0] = ($urandom_range(0, 3) != 0);
        tick(1, 'h10, d);
      end else if (r == 1) tick(1, 'h20, d);
      else if (r == 2) tick(1, 'h30, d);
      else if (r == 3) tick(1, ua, d);
      else tick(0, 0, 0);
      check_model($sformatf("rnd%0d", i));
    end

    tick(1, 'h10, 'h1);
    tick(1, 'h20, 'h1357);
    for (int i = 0; i < 4; i++) tick(0, 0, 0);
    #2 rstn = 1'b0;
    #1;
    check("midreset valid", int'(out_valid), 0);
    check("midreset dout", int'(dout), 0);
    @(negedge clk);
    check("held reset dout", int'(dout), 0);
    model_reset();
    rstn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(0, 0, 0);
      check_model($sformatf("rerun%0d", i));
    end
    check("rerun first sample", int'(dout), 4146);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
